// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage_pkg
// Brief    : Shared RISC-V ALU op codes, operand select encodings, issue entry.
// Revision : 1.0 - initial release
// ============================================================================
package alu_issue_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2,
        A_SEL_RSVD = 2'd3
    } a_sel_e;

    typedef enum logic [1:0] {
        B_SEL_RS2  = 2'd0,
        B_SEL_IMM  = 2'd1,
        B_SEL_FOUR = 2'd2,
        B_SEL_RSVD = 2'd3
    } b_sel_e;

    localparam logic [31:0] c_b_four = 32'd4;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_we;
    } issue_entry_t;

    // x0 is hardwired to zero, so a bypass targeting it must never win.
    function automatic logic [31:0] fwd_pick(
        input logic [4:0]  src_addr,
        input logic [31:0] src_data,
        input logic        fwd_valid,
        input logic [4:0]  fwd_rd,
        input logic [31:0] fwd_data
    );
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == src_addr)) begin
            return fwd_data;
        end
        return src_data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_operand_mux.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_mux
// Brief    : Writeback bypass followed by ALU operand A/B selection.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_mux
    import alu_issue_stage_pkg::*;
(
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_a_sel,
    input  logic [1:0]  i_b_sel,
    input  logic        i_fwd_valid,
    input  logic [4:0]  i_fwd_rd,
    input  logic [31:0] i_fwd_data,
    output logic [31:0] o_a,
    output logic [31:0] o_b
);

    logic [31:0] w_rs1;
    logic [31:0] w_rs2;

    always_comb begin
        w_rs1 = fwd_pick(i_rs1_addr, i_rs1_data, i_fwd_valid, i_fwd_rd, i_fwd_data);
        w_rs2 = fwd_pick(i_rs2_addr, i_rs2_data, i_fwd_valid, i_fwd_rd, i_fwd_data);

        case (i_a_sel)
            A_SEL_RS1: o_a = w_rs1;
            A_SEL_PC:  o_a = i_pc;
            default:   o_a = 32'd0;
        endcase

        case (i_b_sel)
            B_SEL_RS2:  o_b = w_rs2;
            B_SEL_IMM:  o_b = i_imm;
            B_SEL_FOUR: o_b = c_b_four;
            default:    o_b = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Brief    : Decode-to-ALU issue stage: bypass/select plus 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rs2_addr,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_pc,
    input  logic [1:0]  in_a_sel,
    input  logic [1:0]  in_b_sel,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_we,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    buf_state_e   r_state;
    buf_state_e   w_state_next;
    issue_entry_t r_main;
    issue_entry_t r_skid;
    issue_entry_t w_main_next;
    issue_entry_t w_skid_next;
    issue_entry_t w_new;
    logic         r_in_ready;
    logic [15:0]  r_stall_cnt;
    logic [31:0]  w_a;
    logic [31:0]  w_b;
    logic         w_accept;
    logic         w_pop;

    alu_operand_mux u_operand_mux (
        .i_rs1_addr  (in_rs1_addr),
        .i_rs2_addr  (in_rs2_addr),
        .i_rs1_data  (in_rs1_data),
        .i_rs2_data  (in_rs2_data),
        .i_imm       (in_imm),
        .i_pc        (in_pc),
        .i_a_sel     (in_a_sel),
        .i_b_sel     (in_b_sel),
        .i_fwd_valid (fwd_valid),
        .i_fwd_rd    (fwd_rd),
        .i_fwd_data  (fwd_data),
        .o_a         (w_a),
        .o_b         (w_b)
    );

    assign w_new     = '{op: in_op, a: w_a, b: w_b, rd: in_rd, rd_we: in_rd_we};
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid && r_in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        if (flush) begin
            // Held data stays in place; only occupancy is cleared.
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ST_ONE;
                        w_main_next  = w_new;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_next = w_new;
                    end else if (w_accept) begin
                        w_state_next = ST_TWO;
                        w_skid_next  = w_new;
                    end else if (w_pop) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_next = ST_ONE;
                        w_main_next  = r_skid;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_main     <= w_main_next;
            r_skid     <= w_skid_next;
            r_in_ready <= (w_state_next != ST_TWO);
            if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_op    = r_main.op;
    assign out_a     = r_main.a;
    assign out_b     = r_main.b;
    assign out_rd    = r_main.rd;
    assign out_rd_we = r_main.rd_we;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
